axis_packet_fifo: RTL
=====================

AXIS_PACKET_FIFO -- requirements
Module: axis_packet_fifo

Interface
REQ-001 SHALL have parameter AXIS_BYTES, default 1: tdata width in bytes.
REQ-002 SHALL have parameter DEPTH, default 1024: storage in beats; power of two, at least 4.
REQ-003 SHALL have port clk, input, 1: the single clock, with all logic on its rising edge.
REQ-004 SHALL have port sreset, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have ports axis_i_tready (output, 1), axis_i_tvalid (input, 1), axis_i_tlast (input, 1), axis_i_tdata (input, AXIS_BYTES*8): the write-side AXI-Stream slave.
REQ-006 SHALL have ports axis_o_tready (input, 1), axis_o_tvalid (output, 1), axis_o_tlast (output, 1), axis_o_tdata (output, AXIS_BYTES*8): the read-side AXI-Stream master.
REQ-007 SHALL have port drop_pulse, output, 1: high for exactly one cycle per discarded packet.

Function
REQ-008 SHALL store beats plus tlast and emit them in order, unmodified; store-and-forward, releasing a packet only after its tlast beat is written.
REQ-009 SHALL transfer a beat on either side only in a cycle where tvalid and tready are both high.
REQ-010 SHALL keep pointers wr_ptr, commit_ptr and rd_ptr, each log2(DEPTH)+1 bits, wrapping modulo 2*DEPTH.
- Occupancy = wr_ptr - rd_ptr.
- full = occupancy == DEPTH.
REQ-011 SHALL advance wr_ptr by one on each accepted beat while in state WRITE.
REQ-012 SHALL set commit_ptr to the post-increment wr_ptr in the cycle after a tlast beat is accepted in state WRITE.
REQ-013 SHALL implement an input FSM with two states, WRITE (the reset state) and DROP.
REQ-014 SHALL drive axis_i_tready = !full in state WRITE and axis_i_tready = 1 in state DROP.
REQ-015 SHALL move WRITE -> DROP when all three conditions hold in the same cycle:
- full is true;
- rd_ptr == commit_ptr, so no committed data remains;
- axis_i_tlast was not yet seen for the current packet.
On that transition the block rewinds wr_ptr to commit_ptr and pulses drop_pulse on the following cycle.
REQ-016 SHALL, in state DROP, accept and discard every beat, leaving pointers unchanged, and return to WRITE in the cycle after the tlast beat is accepted.
REQ-017 SHALL accept and commit a packet of exactly DEPTH beats arriving into an empty FIFO; the DROP condition is evaluated only when a non-last beat would be needed beyond full.
REQ-018 SHALL drive axis_o_tvalid high exactly 2 cycles after the tlast acceptance cycle when the FIFO was previously empty (commit at +1, output register loaded at +2).
REQ-019 SHALL hold axis_o_tdata and axis_o_tlast stable while axis_o_tvalid=1 and axis_o_tready=0.
REQ-020 SHALL sustain one beat per cycle on the output with first-word-fall-through behaviour while committed data is available; no bubbles between or within committed packets.
REQ-021 SHALL hold axis_o_tvalid low whenever rd_ptr == commit_ptr and the output register is empty; uncommitted beats are never visible.
REQ-022 SHALL handle simultaneous write, commit and read in one cycle with no loss or duplication.
REQ-023 SHALL make slots freed by a read in cycle N writable from cycle N+1.
REQ-024 SHALL accept beats with axis_i_tlast=1 and tdata arbitrary as single-beat packets.

Reset
REQ-025 SHALL, on sreset=1, force all pointers to 0, the FSM to WRITE, and drive axis_o_tvalid=0, axis_o_tlast=0, axis_o_tdata=0, drop_pulse=0, axis_i_tready=1 in the following cycle.
REQ-026 SHALL discard committed and partial packets when reset is asserted mid-packet; after release the block behaves as freshly reset, and leftover beats of the interrupted packet are treated as a new packet.
REQ-027 SHALL give sreset priority over all simultaneous handshakes.

Verification (DEPTH=8, AXIS_BYTES=1)
REQ-028 SHALL cover a single packet:
- Stimulus: write 3 beats 0x11, 0x22, 0x33 (tlast on 0x33) with axis_o_tready=1.
- Required response: no axis_o_tvalid before tlast+2 cycles, then 0x11, 0x22, 0x33 on consecutive cycles, tlast on 0x33.
REQ-029 SHALL cover hold-off:
- Stimulus: write 5 beats with no tlast.
- Required response: axis_o_tvalid stays 0 for 20 cycles; the tlast beat then releases all 6 beats.
REQ-030 SHALL cover an oversize packet:
- Stimulus: a 12-beat packet into an empty FIFO.
- Required response: drop_pulse fires once, all 12 beats are accepted, nothing is output, and a following 2-beat packet outputs intact.
REQ-031 SHALL cover exact fit:
- Stimulus: an 8-beat packet into an empty FIFO with axis_o_tready=0.
- Required response: the packet is committed, axis_i_tready=0 afterwards, and all 8 beats drain once axis_o_tready=1.
REQ-032 SHALL cover backpressure:
- Stimulus: random axis_o_tready at 50%, random input gaps, 200 packets of 1-7 beats.
- Required response: the output sequence equals the input sequence, no drops, and output data is stable during stalls.
REQ-033 SHALL cover reset mid-packet:
- Stimulus: assert sreset after 4 beats of a 6-beat packet while 1 committed packet is pending.
- Required response: axis_o_tvalid=0 and axis_i_tready=1 after reset, and no beat of either packet ever appears.

Source files
------------

// File: rtl/axis_packet_fifo.sv
// Store-and-forward AXI-Stream packet FIFO.
// Beats are written behind wr_ptr and become visible to the reader only once
// the packet's tlast beat has been written (commit_ptr). A packet that cannot
// fit even after all committed data has drained is discarded: the write
// pointer is rewound and the rest of the packet is swallowed.
// The read side keeps one output register that is filled first-word-fall-through
// from the committed region. rd_ptr moves only on an output handshake, so the
// beat held in that register still counts toward occupancy.
module axis_packet_fifo #(
  parameter int AXIS_BYTES = 1,
  parameter int DEPTH      = 1024
) (
  input  logic                    clk,
  input  logic                    sreset,
  output logic                    axis_i_tready,
  input  logic                    axis_i_tvalid,
  input  logic                    axis_i_tlast,
  input  logic [AXIS_BYTES*8-1:0] axis_i_tdata,
  input  logic                    axis_o_tready,
  output logic                    axis_o_tvalid,
  output logic                    axis_o_tlast,
  output logic [AXIS_BYTES*8-1:0] axis_o_tdata,
  output logic                    drop_pulse
);

  localparam int DW = AXIS_BYTES * 8;
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic {
    WRITE = 1'b0,
    DROP  = 1'b1
  } state_t;

  state_t        state;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] commit_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_next;
  logic [PW-1:0] occupancy;
  logic          full;
  logic          in_hs;
  logic          out_hs;
  logic          drop_go;
  logic          load;

  // Storage word is {tlast, tdata}.
  logic [DW:0]   mem [DEPTH];

  assign occupancy     = wr_ptr - rd_ptr;
  assign full          = (occupancy == PW'(DEPTH));
  assign axis_i_tready = (state == DROP) || !full;
  assign in_hs         = axis_i_tvalid && axis_i_tready;
  assign out_hs        = axis_o_tvalid && axis_o_tready;

  // Full with nothing committed left means the whole buffer is one unfinished
  // packet: it can never complete, so give it up. A full buffer holding a
  // finished packet has its tlast already committed and never lands here.
  assign drop_go       = (state == WRITE) && full && (rd_ptr == commit_ptr);

  // Head of the FIFO after this cycle's output handshake (if any).
  assign rd_next       = rd_ptr + {{(PW-1){1'b0}}, out_hs};

  // Refill the output register whenever it is (or is becoming) empty and a
  // committed beat exists at the new head.
  assign load          = (!axis_o_tvalid || out_hs) && (rd_next != commit_ptr);

  // Storage write; only beats accepted in WRITE are kept.
  always_ff @(posedge clk) begin
    if (!sreset && state == WRITE && in_hs)
      mem[wr_ptr[AW-1:0]] <= {axis_i_tlast, axis_i_tdata};
  end

  // Input FSM: write pointer, commit pointer and drop handling.
  always_ff @(posedge clk) begin
    if (sreset) begin
      state      <= WRITE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= 1'b0;
      case (state)
        WRITE: begin
          if (drop_go) begin
            // tready is low while full, so no beat is lost on this edge.
            state      <= DROP;
            wr_ptr     <= commit_ptr;
            drop_pulse <= 1'b1;
          end else if (in_hs) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (axis_i_tlast)
              commit_ptr <= wr_ptr + 1'b1;
          end
        end
        DROP: begin
          if (in_hs && axis_i_tlast)
            state <= WRITE;
        end
        default: state <= WRITE;
      endcase
    end
  end

  // Output register: first-word-fall-through from the committed region.
  always_ff @(posedge clk) begin
    if (sreset) begin
      rd_ptr        <= '0;
      axis_o_tvalid <= 1'b0;
      axis_o_tlast  <= 1'b0;
      axis_o_tdata  <= '0;
    end else begin
      rd_ptr <= rd_next;
      if (load) begin
        axis_o_tvalid                <= 1'b1;
        {axis_o_tlast, axis_o_tdata} <= mem[rd_next[AW-1:0]];
      end else if (out_hs) begin
        axis_o_tvalid <= 1'b0;
      end
    end
  end

endmodule
